// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_scoreboard: register file with per-entry reservation scoreboard,   |
// | tag-matched writeback, flush and two bypassing combinational read ports.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module regfile_scoreboard #(
  parameter int WORD     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int TAGW     = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rsv_i,
  input  logic [AW-1:0]   rsv_addr_i,
  input  logic [TAGW-1:0] rsv_tag_i,
  input  logic            wb_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [TAGW-1:0] wb_tag_i,
  input  logic [WORD-1:0] wb_data_i,
  input  logic            flush_i,
  input  logic [AW-1:0]   ra_addr_i,
  output logic [WORD-1:0] ra_data_o,
  output logic            ra_ready_o,
  input  logic [AW-1:0]   rb_addr_i,
  output logic [WORD-1:0] rb_data_o,
  output logic            rb_ready_o,
  output logic            busy_o
);

  logic [WORD-1:0] r_data [NREG];
  logic [TAGW-1:0] r_tag  [NREG];
  logic [NREG-1:0] r_rsvd;

  logic w_wb_zero;
  logic w_rsv_zero;
  logic w_acc;
  logic w_rsv_en;

  assign w_wb_zero  = (ZERO_REG != 0) && (wb_addr_i == '0);
  assign w_rsv_zero = (ZERO_REG != 0) && (rsv_addr_i == '0);

  // A writeback only retires if it belongs to the most recent producer.
  assign w_acc    = wb_i && r_rsvd[wb_addr_i] && (r_tag[wb_addr_i] == wb_tag_i) && !w_wb_zero;
  assign w_rsv_en = rsv_i && !flush_i && !w_rsv_zero;

  // Later statements win: a same-register reserve re-arms the entry after the retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsvd <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else begin
      if (w_acc) begin
        r_data[wb_addr_i] <= wb_data_i;
        r_rsvd[wb_addr_i] <= 1'b0;
      end
      if (flush_i) begin
        r_rsvd <= '0;
      end
      if (w_rsv_en) begin
        r_rsvd[rsv_addr_i] <= 1'b1;
        r_tag[rsv_addr_i]  <= rsv_tag_i;
      end
    end
  end

  always_comb begin
    ra_data_o  = r_data[ra_addr_i];
    ra_ready_o = !r_rsvd[ra_addr_i];
    if ((BYPASS != 0) && w_acc && (wb_addr_i == ra_addr_i)) begin
      ra_data_o  = wb_data_i;
      ra_ready_o = 1'b1;
    end
    if ((ZERO_REG != 0) && (ra_addr_i == '0)) begin
      ra_data_o  = '0;
      ra_ready_o = 1'b1;
    end
  end

  always_comb begin
    rb_data_o  = r_data[rb_addr_i];
    rb_ready_o = !r_rsvd[rb_addr_i];
    if ((BYPASS != 0) && w_acc && (wb_addr_i == rb_addr_i)) begin
      rb_data_o  = wb_data_i;
      rb_ready_o = 1'b1;
    end
    if ((ZERO_REG != 0) && (rb_addr_i == '0)) begin
      rb_data_o  = '0;
      rb_ready_o = 1'b1;
    end
  end

  assign busy_o = |r_rsvd;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// Bench for regfile_scoreboard: directed vector table, random traffic against a
// behavioural register-file model, and BYPASS=0 / reset corner sequences.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rsv = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic [3:0]  rsv_tag = '0;
  logic        wb = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [3:0]  wb_tag = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic [4:0]  ra_addr = '0;
  logic [4:0]  rb_addr = '0;

  logic [31:0] a_ra_data, a_rb_data, n_ra_data, n_rb_data;
  logic        a_ra_ready, a_rb_ready, a_busy, n_ra_ready, n_rb_ready, n_busy;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.WORD(32), .NREG(32), .AW(5), .TAGW(4), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr), .rsv_tag_i(rsv_tag),
    .wb_i(wb), .wb_addr_i(wb_addr), .wb_tag_i(wb_tag), .wb_data_i(wb_data),
    .flush_i(flush),
    .ra_addr_i(ra_addr), .ra_data_o(a_ra_data), .ra_ready_o(a_ra_ready),
    .rb_addr_i(rb_addr), .rb_data_o(a_rb_data), .rb_ready_o(a_rb_ready),
    .busy_o(a_busy)
  );

  regfile_scoreboard #(.WORD(32), .NREG(32), .AW(5), .TAGW(4), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr), .rsv_tag_i(rsv_tag),
    .wb_i(wb), .wb_addr_i(wb_addr), .wb_tag_i(wb_tag), .wb_data_i(wb_data),
    .flush_i(flush),
    .ra_addr_i(ra_addr), .ra_data_o(n_ra_data), .ra_ready_o(n_ra_ready),
    .rb_addr_i(rb_addr), .rb_data_o(n_rb_data), .rb_ready_o(n_rb_ready),
    .busy_o(n_busy)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_data [32];
  logic [3:0]  m_tag  [32];
  bit          m_rsvd [32];

  typedef struct {
    logic        rsv;
    logic [4:0]  rsv_addr;
    logic [3:0]  rsv_tag;
    logic        wb;
    logic [4:0]  wb_addr;
    logic [3:0]  wb_tag;
    logic [31:0] wb_data;
    logic        flush;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea_d;
    logic        ea_r;
    logic [31:0] eb_d;
    logic        eb_r;
    logic        ebusy;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic r, input int ra_, input int rt, input logic w, input int wa,
                              input int wt, input logic [31:0] wd, input logic f, input int pa, input int pb,
                              input logic [31:0] ead, input logic ear, input logic [31:0] ebd,
                              input logic ebr, input logic eby);
    vec_t v;
    v.rsv = r; v.rsv_addr = 5'(ra_); v.rsv_tag = 4'(rt);
    v.wb = w; v.wb_addr = 5'(wa); v.wb_tag = 4'(wt); v.wb_data = wd;
    v.flush = f; v.ra = 5'(pa); v.rb = 5'(pb);
    v.ea_d = ead; v.ea_r = ear; v.eb_d = ebd; v.eb_r = ebr; v.ebusy = eby;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_accepts();
    return wb && (wb_addr != 5'd0) && m_rsvd[wb_addr] && (m_tag[wb_addr] == wb_tag);
  endfunction

  task automatic model_read(input logic [4:0] addr, input bit byp, output logic [31:0] d, output logic r);
    if (addr == 5'd0) begin
      d = '0; r = 1'b1;
    end else if (byp && model_accepts() && (wb_addr == addr)) begin
      d = wb_data; r = 1'b1;
    end else begin
      d = m_data[addr]; r = !m_rsvd[addr];
    end
  endtask

  function automatic logic model_busy();
    logic b = 1'b0;
    for (int i = 0; i < 32; i++) b = b | m_rsvd[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = '0; m_tag[i] = '0; m_rsvd[i] = 1'b0;
    end
  endtask

  // Applies the architectural rules of one clock edge to the model.
  task automatic model_update();
    bit acc = model_accepts();
    if (acc) begin
      m_data[wb_addr] = wb_data;
      m_rsvd[wb_addr] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_rsvd[i] = 1'b0;
    end else if (rsv && rsv_addr != 5'd0) begin
      m_rsvd[rsv_addr] = 1'b1;
      m_tag[rsv_addr]  = rsv_tag;
    end
  endtask

  task automatic model_check();
    logic [31:0] d;
    logic        r;
    model_read(ra_addr, 1'b1, d, r);
    check("byp ra_data", a_ra_data, d);
    check("byp ra_ready", a_ra_ready, r);
    model_read(rb_addr, 1'b1, d, r);
    check("byp rb_data", a_rb_data, d);
    check("byp rb_ready", a_rb_ready, r);
    check("byp busy", a_busy, model_busy());
    model_read(ra_addr, 1'b0, d, r);
    check("nobyp ra_data", n_ra_data, d);
    check("nobyp ra_ready", n_ra_ready, r);
    model_read(rb_addr, 1'b0, d, r);
    check("nobyp rb_data", n_rb_data, d);
    check("nobyp rb_ready", n_rb_ready, r);
    check("nobyp busy", n_busy, model_busy());
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic r, input int ra_, input int rt, input logic w, input int wa,
                       input int wt, input logic [31:0] wd, input logic f, input int pa, input int pb);
    rsv = r; rsv_addr = 5'(ra_); rsv_tag = 4'(rt);
    wb = w; wb_addr = 5'(wa); wb_tag = 4'(wt); wb_data = wd;
    flush = f; ra_addr = 5'(pa); rb_addr = 5'(pb);
  endtask

  task automatic idle(input int pa, input int pb);
    drive(1'b0, 0, 0, 1'b0, 0, 0, 32'h0, 1'b0, pa, pb);
  endtask

  initial begin
    tbl[0]  = mk(0,0,0, 0,0,0,32'h0,          0, 3,5, 32'h0,1, 32'h0,1, 0);
    tbl[1]  = mk(1,3,2, 0,0,0,32'h0,          0, 3,0, 32'h0,1, 32'h0,1, 0);
    tbl[2]  = mk(0,0,0, 0,0,0,32'h0,          0, 3,0, 32'h0,0, 32'h0,1, 1);
    tbl[3]  = mk(0,0,0, 1,3,2,32'hDEADBEEF,   0, 3,3, 32'hDEADBEEF,1, 32'hDEADBEEF,1, 1);
    tbl[4]  = mk(0,0,0, 0,0,0,32'h0,          0, 3,3, 32'hDEADBEEF,1, 32'hDEADBEEF,1, 0);
    tbl[5]  = mk(1,7,1, 0,0,0,32'h0,          0, 7,0, 32'h0,1, 32'h0,1, 0);
    tbl[6]  = mk(1,7,4, 0,0,0,32'h0,          0, 7,0, 32'h0,0, 32'h0,1, 1);
    tbl[7]  = mk(0,0,0, 1,7,1,32'h11,         0, 7,0, 32'h0,0, 32'h0,1, 1);
    tbl[8]  = mk(0,0,0, 1,7,4,32'h44,         0, 7,7, 32'h44,1, 32'h44,1, 1);
    tbl[9]  = mk(0,0,0, 0,0,0,32'h0,          0, 7,3, 32'h44,1, 32'hDEADBEEF,1, 0);
    tbl[10] = mk(1,9,3, 0,0,0,32'h0,          0, 9,0, 32'h0,1, 32'h0,1, 0);
    tbl[11] = mk(1,9,6, 1,9,3,32'hA5,         0, 9,9, 32'hA5,1, 32'hA5,1, 1);
    tbl[12] = mk(0,0,0, 0,0,0,32'h0,          0, 9,0, 32'hA5,0, 32'h0,1, 1);
    tbl[13] = mk(0,0,0, 1,9,6,32'h66,         0, 9,0, 32'h66,1, 32'h0,1, 1);
    tbl[14] = mk(0,0,0, 0,0,0,32'h0,          0, 9,0, 32'h66,1, 32'h0,1, 0);
    tbl[15] = mk(1,1,1, 0,0,0,32'h0,          0, 1,2, 32'h0,1, 32'h0,1, 0);
    tbl[16] = mk(1,2,2, 0,0,0,32'h0,          0, 1,2, 32'h0,0, 32'h0,1, 1);
    tbl[17] = mk(1,4,3, 0,0,0,32'h0,          0, 1,2, 32'h0,0, 32'h0,0, 1);
    tbl[18] = mk(1,5,5, 1,2,2,32'h22,         1, 4,2, 32'h0,0, 32'h22,1, 1);
    tbl[19] = mk(0,0,0, 0,0,0,32'h0,          0, 5,2, 32'h0,1, 32'h22,1, 0);
    tbl[20] = mk(0,0,0, 0,0,0,32'h0,          0, 1,4, 32'h0,1, 32'h0,1, 0);
    tbl[21] = mk(1,0,1, 1,0,1,32'hFF,         0, 0,0, 32'h0,1, 32'h0,1, 0);
    tbl[22] = mk(0,0,0, 0,0,0,32'h0,          0, 0,0, 32'h0,1, 32'h0,1, 0);
    tbl[23] = mk(0,0,0, 1,3,2,32'h1234,       0, 3,3, 32'hDEADBEEF,1, 32'hDEADBEEF,1, 0);
    tbl[24] = mk(0,0,0, 0,0,0,32'h0,          0, 3,9, 32'hDEADBEEF,1, 32'h66,1, 0);

    model_reset();

    // Power-on reset state.
    ra_addr = 5'd5; rb_addr = 5'd31;
    #1;
    check("reset busy", a_busy, 32'h0);
    check("reset ra_ready", a_ra_ready, 32'h1);
    check("reset ra_data", a_ra_data, 32'h0);
    check("reset rb_data", a_rb_data, 32'h0);
    #21 rst = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rsv, tbl[i].rsv_addr, tbl[i].rsv_tag, tbl[i].wb, tbl[i].wb_addr,
            tbl[i].wb_tag, tbl[i].wb_data, tbl[i].flush, tbl[i].ra, tbl[i].rb);
      @(negedge clk);
      check($sformatf("vec%0d ra_data", i), a_ra_data, tbl[i].ea_d);
      check($sformatf("vec%0d ra_ready", i), a_ra_ready, tbl[i].ea_r);
      check($sformatf("vec%0d rb_data", i), a_rb_data, tbl[i].eb_d);
      check($sformatf("vec%0d rb_ready", i), a_rb_ready, tbl[i].eb_r);
      check($sformatf("vec%0d busy", i), a_busy, tbl[i].ebusy);
      model_check();
      finish_cycle();
    end

    // Without bypass an accepted writeback shows up one cycle later.
    drive(1'b1, 12, 5, 1'b0, 0, 0, 32'h0, 1'b0, 12, 0);
    @(negedge clk); model_check(); finish_cycle();
    drive(1'b0, 0, 0, 1'b1, 12, 5, 32'hCAFE0012, 1'b0, 12, 12);
    @(negedge clk);
    check("nobyp same-cycle data", n_ra_data, 32'h0);
    check("nobyp same-cycle ready", n_ra_ready, 32'h0);
    check("byp same-cycle data", a_ra_data, 32'hCAFE0012);
    model_check(); finish_cycle();
    idle(12, 0);
    @(negedge clk);
    check("nobyp next-cycle data", n_ra_data, 32'hCAFE0012);
    check("nobyp next-cycle ready", n_ra_ready, 32'h1);
    model_check(); finish_cycle();
    drive(1'b1, 0, 2, 1'b1, 0, 0, 32'hFF, 1'b0, 0, 0);
    @(negedge clk);
    check("nobyp r0 rb_data", n_rb_data, 32'h0);
    check("nobyp r0 rb_ready", n_rb_ready, 32'h1);
    model_check(); finish_cycle();
    idle(0, 0);
    @(negedge clk);
    check("nobyp r0 busy", n_busy, 32'h0);
    check("nobyp r0 later data", n_rb_data, 32'h0);
    model_check(); finish_cycle();

    // Random traffic on a narrow address window so reservations collide often.
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] wa;
      wa = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rsv      = 1'($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      rsv_tag  = 4'($urandom_range(0, 3));
      wb       = 1'($urandom_range(0, 1));
      wb_addr  = wa;
      wb_tag   = ($urandom_range(0, 2) != 0) ? m_tag[wa] : 4'($urandom_range(0, 3));
      wb_data  = $urandom;
      flush    = 1'($urandom_range(0, 31) == 0);
      ra_addr  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
      rb_addr  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      @(negedge clk);
      model_check();
      finish_cycle();
    end

    // Asynchronous reset mid-run with live reservations.
    idle(5, 31);
    @(negedge clk); model_check(); finish_cycle();
    drive(1'b1, 5, 1, 1'b0, 0, 0, 32'h0, 1'b0, 5, 31);
    @(negedge clk); model_check(); finish_cycle();
    drive(1'b1, 31, 3, 1'b1, 5, 1, 32'h55, 1'b0, 5, 31);
    @(negedge clk); model_check(); finish_cycle();
    drive(1'b1, 5, 2, 1'b0, 0, 0, 32'h0, 1'b0, 5, 31);
    @(negedge clk); model_check(); finish_cycle();
    idle(5, 31);
    @(negedge clk);
    check("pre-reset busy", a_busy, 32'h1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("mid reset busy", a_busy, 32'h0);
    check("mid reset ra_ready r5", a_ra_ready, 32'h1);
    check("mid reset ra_data r5", a_ra_data, 32'h0);
    check("mid reset rb_ready r31", a_rb_ready, 32'h1);
    check("mid reset rb_data r31", a_rb_data, 32'h0);
    check("mid reset nobyp busy", n_busy, 32'h0);
    ra_addr = 5'd31;
    #1;
    check("mid reset ra_data r31", a_ra_data, 32'h0);
    check("mid reset ra_ready r31", a_ra_ready, 32'h1);
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); model_check(); finish_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-entry register file with a per-entry write-reservation scoreboard and tagged writeback. It is the decode/writeback-stage successor to the single register cell. Decode reserves a destination register with a producer tag. Writeback retires data only if its tag matches the current reservation, so stale WAW results are discarded. Two combinational read ports report data plus a ready flag, with optional same-cycle writeback bypass, and a flush clears all reservations.

Parameters:
WORD, 32, data width in bits
NREG, 32, number of registers (power of two)
AW, 5, register address width, log2(NREG)
TAGW, 4, producer tag width
ZERO_REG, 1, 1 = register 0 reads as zero, is never reserved and ignores writes
BYPASS, 1, 1 = read ports forward a same-cycle accepted writeback

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
rsv_i  in  1  reserve request
rsv_addr_i  in  AW  register to reserve
rsv_tag_i  in  TAGW  producer tag stored with the reservation
wb_i  in  1  writeback request
wb_addr_i  in  AW  writeback register
wb_tag_i  in  TAGW  writeback producer tag
wb_data_i  in  WORD  writeback data
flush_i  in  1  clear all reservations
ra_addr_i  in  AW  read port A address
ra_data_o  out  WORD  read port A data
ra_ready_o  out  1  port A entry not reserved (or bypassed)
rb_addr_i  in  AW  read port B address
rb_data_o  out  WORD  read port B data
rb_ready_o  out  1  port B entry not reserved (or bypassed)
busy_o  out  1  OR of all reservation bits

Behaviour:
- State per entry: data[WORD], rsvd[1], tag[TAGW].
- Reset (rst=0, asynchronous):
  - all data = 0, rsvd = 0, tag = 0.
  - Outputs then: ra/rb_data_o = 0, ra/rb_ready_o = 1, busy_o = 0.
- Writeback acceptance (per cycle):
  - acc = wb_i & rsvd[wb_addr_i] & (tag[wb_addr_i] == wb_tag_i) & ~(ZERO_REG & wb_addr_i == 0).
  - On acc: data <= wb_data_i and rsvd <= 0 at the next edge.
  - A non-matching, unreserved or reg-0 writeback is dropped silently. It causes no state change and no error.
- Reserve: rsv_i with a non-zero address (or any address if ZERO_REG=0) sets rsvd <= 1 and tag <= rsv_tag_i at the next edge.
  - A re-reserve of an already reserved entry overwrites the tag. The earlier producer's writeback then no longer matches (WAW handling).
- Reserve and accepted writeback to the same register in the same cycle:
  - data takes wb_data_i (matched against the OLD tag).
  - rsvd stays 1 and tag becomes rsv_tag_i.
- Reserve and writeback to different registers: both are applied independently.
- flush_i:
  - Clears every rsvd bit at the next edge.
  - Has priority over a same-cycle reserve, which is dropped.
  - An accepted writeback in the same cycle still writes its data.
  - Tags are left unchanged.
- Reads are combinational, with zero-cycle latency from address to data.
  - ready = ~rsvd[addr].
  - Register 0 reads data=0, ready=1 when ZERO_REG=1.
- Bypass (BYPASS=1): if acc and wb_addr_i == port address, the port returns wb_data_i with ready=1 in the same cycle.
  - Bypass applies even when flush_i or a same-register reserve is present.
  - With BYPASS=0 the port returns stored data/ready, and the update is visible on the next cycle.
- busy_o is the registered-state OR of all rsvd bits, combinational from state.
- Out-of-range addresses cannot occur because NREG = 2^AW.

Test Plan:
- Reset: assert rst=0 mid-run with entries reserved -> immediately busy_o=0, ra_ready_o=1, ra_data_o=0 for addr 5 and 31.
- Reserve/writeback: rsv addr 3 tag 2 -> next cycle ra_ready_o=0. wb addr 3 tag 2 data 0xDEADBEEF -> same cycle (BYPASS=1) ra_data_o=0xDEADBEEF with ready=1, next cycle stored, busy_o=0.
- WAW: rsv r7 tag 1, then rsv r7 tag 4. wb r7 tag 1 data 0x11 -> dropped, r7 still reserved with old data. wb r7 tag 4 data 0x44 -> r7=0x44, ready=1.
- Simultaneous: r9 reserved tag 3. In one cycle, wb r9 tag 3 data 0xA5 and rsv r9 tag 6 -> r9 data=0xA5, still reserved, and a later wb tag 6 is accepted.
- Flush: reserve r1, r2, r4, then flush_i together with rsv r5 and matching wb r2 data 0x22 -> all ready=1, r5 not reserved, r2=0x22, busy_o=0.
- Register 0 (ZERO_REG=1): rsv r0 and wb r0 data 0xFF -> rb_data_o=0, rb_ready_o=1, busy_o=0. Repeat with BYPASS=0 -> bypass absent, data visible one cycle later.
